wb_interconnect: RTL
====================

# wb_interconnect

Single-master, parametrised Wishbone (classic, non-pipelined) interconnect that sits between the CPU core's bus port and NUM_SLAVES memory or peripheral slaves (program memory, data RAM, GPIO, …) in the SoC top. It decodes each master cycle by base/mask, registers the request toward the selected slave, and returns the registered ack/err/rdata. It generates a bus error for unmapped addresses and for slaves that do not respond within a bounded time.

## Interface
Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8); SEL width = DATA_WIDTH/8
- SLAVE_BASE, all zero, packed NUM_SLAVES*ADDR_WIDTH; slot i = base of slave i
- SLAVE_MASK, all zero, packed NUM_SLAVES*ADDR_WIDTH; slave i hits when (addr & mask_i) == base_i
- TIMEOUT_CYCLES, 255, max REQ cycles before timeout error (>= 1)

Ports:
- clk_in  in  1  clock, all logic on rising edge
- reset_in  in  1  asynchronous, active-low reset
- m_cyc, m_stb, m_we  in  1 each  master cycle/strobe/write-enable
- m_addr  in  ADDR_WIDTH  master address
- m_wdata  in  DATA_WIDTH  master write data
- m_sel  in  DATA_WIDTH/8  master byte selects
- m_rdata  out  DATA_WIDTH  read data to master
- m_ack, m_err  out  1 each  one-cycle response to master
- s_cyc, s_stb  out  NUM_SLAVES each  one-hot cycle/strobe per slave
- s_we  out  1; s_addr  out  ADDR_WIDTH; s_wdata  out  DATA_WIDTH; s_sel  out  DATA_WIDTH/8  broadcast to all slaves
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- s_ack, s_err  in  NUM_SLAVES each  slave responses
- fault_pulse  out  1  one-cycle pulse on unmapped or timeout error
- fault_addr  out  ADDR_WIDTH  address of most recent fault (sticky)

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if m_cyc & m_stb, decode m_addr against all slaves; lowest index wins on overlap.
  - Hit: latch addr/wdata/sel/we and slave index; clear timer; go to REQ.
  - Miss: go to RESP with err flag; fault_addr <= m_addr; fault_pulse=1 for one cycle.
- REQ: s_cyc[idx] = s_stb[idx] = 1 (registered); all other slave strobes 0.
  - s_ack[idx]: capture s_rdata slot idx; go to RESP with ack flag.
  - s_err[idx] (without ack): go to RESP with err flag.
  - Both asserted: ack wins.
  - Neither, and timer == TIMEOUT_CYCLES-1: go to RESP with err flag; fault_addr <= latched addr; fault_pulse.
  - Otherwise timer += 1 (width clog2(TIMEOUT_CYCLES)+1; no wrap possible).
  - m_cyc low: abort. Drop slave strobes next cycle, go to IDLE, no master response.
- RESP: m_ack or m_err = 1 for exactly one cycle; m_rdata holds captured data (zero on err or write); go to IDLE.
- Acks/errs from non-selected slaves are ignored at all times.
- Reset values: state IDLE; all s_cyc/s_stb 0; m_ack, m_err, fault_pulse 0; m_rdata, s_addr, s_wdata, s_sel, s_we, fault_addr 0.
- Reset mid-transaction returns to IDLE immediately. Slave strobes drop asynchronously and no response is issued.

## Timing
- All outputs are registered; there is no combinational path from master inputs to slave outputs or back.
- Request in cycle 0:
  - Slave strobe is first visible in cycle 1.
  - A slave acking in cycle k (k>=1) produces m_ack in cycle k+1.
  - Minimum hit latency: m_ack in cycle 2.
  - Unmapped address: m_err in cycle 1.
  - Timeout: REQ occupies cycles 1..TIMEOUT_CYCLES; m_err in cycle TIMEOUT_CYCLES+1.
- Slave strobes deassert in the cycle after the slave ack/err, which is the RESP cycle.
- IDLE ignores m_stb during RESP. A new request is accepted only in IDLE, so back-to-back throughput is one transaction per 3 cycles minimum.

## Test plan
- Read hit: NUM_SLAVES=4, slave 1 base 0x1000_0000 mask 0xF000_0000, read 0x1000_0004, slave acks in first REQ cycle with 0xDEADBEEF -> s_stb=4'b0010 in cycle 1, m_ack and m_rdata=0xDEADBEEF in cycle 2, strobes 0 in cycle 2.
- Write with sel: write 0xA5A5_5A5A, sel 4'b0011 to slave 0 -> s_we=1, s_wdata/s_sel match; m_ack one cycle; m_rdata=0.
- Unmapped: address 0xF000_0000 with no matching slave -> m_err in cycle 1, no s_stb ever asserted, fault_pulse=1, fault_addr=0xF000_0000.
- Timeout: TIMEOUT_CYCLES=16, slave never acks -> s_stb high for cycles 1..16, m_err in cycle 17, strobe low in cycle 17, fault_addr latched.
- Conflicts: selected slave asserts ack and err together -> m_ack only. Non-selected slave asserts ack during REQ -> ignored.
- Abort and reset: m_cyc drops in REQ cycle 2 -> strobes 0 in cycle 3, no m_ack/m_err. reset_in low mid-REQ -> all outputs 0 immediately; next request is served normally.

Source files
------------

// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master Wishbone classic interconnect.
// Decodes each master cycle against NUM_SLAVES base/mask windows (lowest index
// wins on overlap), forwards a registered request to the selected slave and
// returns a registered one-cycle ack/err with read data. Unmapped addresses and
// slaves that stay silent for TIMEOUT_CYCLES produce a bus error plus a fault
// pulse and a sticky fault address.
//
// Ports:
//   clk_in, reset_in           clock (rising edge), async active-low reset
//   m_cyc/m_stb/m_we/m_addr/
//   m_wdata/m_sel              master request
//   m_rdata/m_ack/m_err        master response (one cycle)
//   s_cyc/s_stb                one-hot per-slave cycle/strobe
//   s_we/s_addr/s_wdata/s_sel  request fields broadcast to all slaves
//   s_rdata/s_ack/s_err        packed slave responses
//   fault_pulse/fault_addr     error pulse and address of most recent fault
module wb_interconnect #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             m_cyc,
    input  logic                             m_stb,
    input  logic                             m_we,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic [DATA_WIDTH/8-1:0]          m_sel,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_ack,
    output logic                             m_err,
    output logic [NUM_SLAVES-1:0]            s_cyc,
    output logic [NUM_SLAVES-1:0]            s_stb,
    output logic                             s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_sel,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ack,
    input  logic [NUM_SLAVES-1:0]            s_err,
    output logic                             fault_pulse,
    output logic [ADDR_WIDTH-1:0]            fault_addr
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TMR_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state, state_d;
    logic [IDX_WIDTH-1:0]  idx, idx_d;
    logic [TMR_WIDTH-1:0]  timer, timer_d;
    logic [NUM_SLAVES-1:0] strobe_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [SEL_WIDTH-1:0]  sel_d;
    logic                  ack_d, err_d, fault_pulse_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [ADDR_WIDTH-1:0] fault_addr_d;

    logic                  dec_hit;
    logic [IDX_WIDTH-1:0]  dec_idx;
    logic                  sel_ack, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Only the latched slave's response is ever looked at.
    assign sel_ack   = s_ack[idx];
    assign sel_err   = s_err[idx];
    assign sel_rdata = s_rdata[idx*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        timer_d       = timer;
        strobe_d      = s_stb;
        we_d          = s_we;
        addr_d        = s_addr;
        wdata_d       = s_wdata;
        sel_d         = s_sel;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        rdata_d       = m_rdata;
        fault_pulse_d = 1'b0;
        fault_addr_d  = fault_addr;

        case (state)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    if (dec_hit) begin
                        state_d  = REQ;
                        idx_d    = dec_idx;
                        timer_d  = '0;
                        strobe_d = NUM_SLAVES'(1) << dec_idx;
                        we_d     = m_we;
                        addr_d   = m_addr;
                        wdata_d  = m_wdata;
                        sel_d    = m_sel;
                    end else begin
                        state_d       = RESP;
                        err_d         = 1'b1;
                        rdata_d       = '0;
                        fault_pulse_d = 1'b1;
                        fault_addr_d  = m_addr;
                    end
                end
            end

            REQ: begin
                if (!m_cyc) begin
                    // Master withdrew: release the slave, no response.
                    state_d  = IDLE;
                    strobe_d = '0;
                end else if (sel_ack) begin
                    state_d  = RESP;
                    strobe_d = '0;
                    ack_d    = 1'b1;
                    rdata_d  = s_we ? '0 : sel_rdata;
                end else if (sel_err) begin
                    state_d  = RESP;
                    strobe_d = '0;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                end else if (timer == TMR_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = RESP;
                    strobe_d      = '0;
                    err_d         = 1'b1;
                    rdata_d       = '0;
                    fault_pulse_d = 1'b1;
                    fault_addr_d  = s_addr;
                end else begin
                    timer_d = timer + TMR_WIDTH'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                strobe_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            s_cyc       <= '0;
            s_stb       <= '0;
            s_we        <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_sel       <= '0;
            m_ack       <= 1'b0;
            m_err       <= 1'b0;
            m_rdata     <= '0;
            fault_pulse <= 1'b0;
            fault_addr  <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            timer       <= timer_d;
            s_cyc       <= strobe_d;
            s_stb       <= strobe_d;
            s_we        <= we_d;
            s_addr      <= addr_d;
            s_wdata     <= wdata_d;
            s_sel       <= sel_d;
            m_ack       <= ack_d;
            m_err       <= err_d;
            m_rdata     <= rdata_d;
            fault_pulse <= fault_pulse_d;
            fault_addr  <= fault_addr_d;
        end
    end

endmodule
